// File: rtl/exec_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stall, taken-branch flush, multi-cycle MUL hold.
// Optional performance counters are built only when EXEC_HAZARD_PERF_EN is defined.
module exec_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int REG_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] IdRn,
    input  logic [REG_W-1:0] IdRm,
    input  logic             IdUsesRm,
    input  logic             ExMemRead,
    input  logic [REG_W-1:0] ExRd,
    input  logic             ExMulStart,
    input  logic             ExBrTaken,
    output logic             PCWrite,
    output logic             IfIdWrite,
    output logic             IfIdFlush,
    output logic             IdExBubble,
    output logic             ExHold,
    output logic             MulDone,
    output logic [15:0]      StallCycles,
    output logic [15:0]      FlushCount
);

    typedef enum logic [0:0] {RUN, MUL_BUSY} state_t;

    localparam logic [REG_W-1:0] XZR        = REG_W'(31);
    localparam bit               MUL_MULTI  = (MUL_CYCLES > 1);
    localparam logic [3:0]       MUL_RELOAD = MUL_MULTI ? 4'(MUL_CYCLES - 2) : 4'd0;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       lu;

    assign lu = ExMemRead && (ExRd != XZR) &&
                ((ExRd == IdRn) || (IdUsesRm && (ExRd == IdRm)));

    // NOTE: every output and next-state value gets a default before the case so no latch is inferred.
    always_comb begin
        PCWrite    = 1'b1;
        IfIdWrite  = 1'b1;
        IfIdFlush  = 1'b0;
        IdExBubble = 1'b0;
        ExHold     = 1'b0;
        MulDone    = 1'b0;
        state_next = state;
        cnt_next   = cnt;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (ExBrTaken) begin
                        IfIdFlush  = 1'b1;
                        IdExBubble = 1'b1;
                    end else if (ExMulStart) begin
                        if (MUL_MULTI) begin
                            ExHold     = 1'b1;
                            PCWrite    = 1'b0;
                            IfIdWrite  = 1'b0;
                            state_next = MUL_BUSY;
                            cnt_next   = MUL_RELOAD;
                        end else begin
                            MulDone = 1'b1;
                        end
                    end else if (lu) begin
                        PCWrite    = 1'b0;
                        IfIdWrite  = 1'b0;
                        IdExBubble = 1'b1;
                    end
                end
                MUL_BUSY: begin
                    // EX contents are frozen, so branch, MUL and load-use inputs are ignored here.
                    if (cnt != 4'd0) begin
                        ExHold    = 1'b1;
                        PCWrite   = 1'b0;
                        IfIdWrite = 1'b0;
                        cnt_next  = cnt - 4'd1;
                    end else begin
                        MulDone    = 1'b1;
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

`ifdef EXEC_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCycles <= 16'd0;
            FlushCount  <= 16'd0;
        end else begin
            if (!PCWrite && (StallCycles != 16'hFFFF))
                StallCycles <= StallCycles + 16'd1;
            if (IfIdFlush && (FlushCount != 16'hFFFF))
                FlushCount <= FlushCount + 16'd1;
        end
    end
`else
    assign StallCycles = 16'd0;
    assign FlushCount  = 16'd0;
`endif

endmodule
